ts_serial_rx: RTL and testbench

Serial transport-stream receiver that sits directly upstream of the TS proxy/FIFO stage. It takes the raw 1-bit serial TS interface of a demodulator (clock, start, valid, data), synchronises it into the system `clk` domain, and assembles MSB-first bytes. It checks packet framing (sync byte, packet length) and emits a byte stream as single-cycle `dval` pulses with a packet-start marker `strt`. That stream is the `strt`/`dval`/`data` input the TS FIFO writer consumes.

---
 rtl/ts_serial_rx.sv | 201 ++++++++++++++++++++
 tb/tb_ts_serial_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ts_serial_rx.sv
// Serial transport-stream receiver: synchronises a demodulator's 1-bit TS
// interface into the clk_i domain, assembles MSB-first bytes, checks packet
// framing (sync byte and length) and emits a dval/strt/data byte stream.
module ts_serial_rx #(
   parameter int unsigned PktLen   = 188,
   parameter logic [7:0]  SyncByte = 8'h47
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        ts_clock_i,
   input  logic        ts_start_i,
   input  logic        ts_valid_i,
   input  logic        ts_data_i,
   input  logic        enable_i,
   output logic [7:0]  data_o,
   output logic        dval_o,
   output logic        strt_o,
   output logic        locked_o,
   output logic [15:0] pkt_cnt_o,
   output logic [7:0]  sync_err_o,
   output logic [7:0]  len_err_o
);

   localparam logic [1:0] StHunt  = 2'd0;
   localparam logic [1:0] StFirst = 2'd1;
   localparam logic [1:0] StBody  = 2'd2;

   localparam logic [7:0] LastIdx = 8'(PktLen - 1);

   // Synchroniser stages
   logic tclk_s1_q, tclk_s2_q, tclk_s3_q;
   logic start_s1_q, start_s2_q;
   logic valid_s1_q, valid_s2_q;
   logic data_s1_q, data_s2_q;

   // Receiver state
   logic [1:0]  state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  shreg_q, shreg_d;
   logic [7:0]  byte_idx_q, byte_idx_d;
   logic [7:0]  data_q, data_d;
   logic        dval_q, dval_d;
   logic        strt_q, strt_d;
   logic        locked_q, locked_d;
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [7:0]  sync_err_q, sync_err_d;
   logic [7:0]  len_err_q, len_err_d;
   // Armed by a completed packet; the first stray bit afterwards is a long-packet error.
   logic        extra_arm_q, extra_arm_d;

   logic       bit_edge;
   logic       bit_take;
   logic [7:0] new_byte;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign bit_edge = tclk_s2_q & ~tclk_s3_q;
   assign bit_take = bit_edge & valid_s2_q;
   assign new_byte = {shreg_q, data_s2_q};

   // Two-flop synchronisers, plus a third ts_clock stage for rising-edge detect
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         tclk_s1_q  <= 1'b0;
         tclk_s2_q  <= 1'b0;
         tclk_s3_q  <= 1'b0;
         start_s1_q <= 1'b0;
         start_s2_q <= 1'b0;
         valid_s1_q <= 1'b0;
         valid_s2_q <= 1'b0;
         data_s1_q  <= 1'b0;
         data_s2_q  <= 1'b0;
      end else begin
         tclk_s1_q  <= ts_clock_i;
         tclk_s2_q  <= tclk_s1_q;
         tclk_s3_q  <= tclk_s2_q;
         start_s1_q <= ts_start_i;
         start_s2_q <= start_s1_q;
         valid_s1_q <= ts_valid_i;
         valid_s2_q <= valid_s1_q;
         data_s1_q  <= ts_data_i;
         data_s2_q  <= data_s1_q;
      end
   end

   // Receiver state, output and counter registers
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= StHunt;
         bit_cnt_q   <= 3'd0;
         shreg_q     <= 7'd0;
         byte_idx_q  <= 8'd0;
         data_q      <= 8'd0;
         dval_q      <= 1'b0;
         strt_q      <= 1'b0;
         locked_q    <= 1'b0;
         pkt_cnt_q   <= 16'd0;
         sync_err_q  <= 8'd0;
         len_err_q   <= 8'd0;
         extra_arm_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         byte_idx_q  <= byte_idx_d;
         data_q      <= data_d;
         dval_q      <= dval_d;
         strt_q      <= strt_d;
         locked_q    <= locked_d;
         pkt_cnt_q   <= pkt_cnt_d;
         sync_err_q  <= sync_err_d;
         len_err_q   <= len_err_d;
         extra_arm_q <= extra_arm_d;
      end
   end

   // Framing FSM: bit assembly, sync/length checks and byte emission
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      byte_idx_d  = byte_idx_q;
      data_d      = data_q;
      dval_d      = 1'b0;
      strt_d      = 1'b0;
      locked_d    = locked_q;
      pkt_cnt_d   = pkt_cnt_q;
      sync_err_d  = sync_err_q;
      len_err_d   = len_err_q;
      extra_arm_d = extra_arm_q;

      if (!enable_i) begin
         // Abort silently; a later stray bit must not look like a long packet.
         state_d     = StHunt;
         extra_arm_d = 1'b0;
      end else if (bit_take) begin
         if (start_s2_q) begin
            // A start inside a packet means the previous one was short.
            if (state_q != StHunt) begin
               len_err_d = sat_inc(len_err_q);
               locked_d  = 1'b0;
            end
            shreg_d     = {6'd0, data_s2_q};
            bit_cnt_d   = 3'd1;
            byte_idx_d  = 8'd0;
            state_d     = StFirst;
            extra_arm_d = 1'b0;
         end else begin
            case (state_q)
               StFirst, StBody: begin
                  shreg_d   = {shreg_q[5:0], data_s2_q};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == StFirst) begin
                        if (new_byte == SyncByte) begin
                           data_d     = new_byte;
                           dval_d     = 1'b1;
                           strt_d     = 1'b1;
                           byte_idx_d = 8'd1;
                           state_d    = StBody;
                        end else begin
                           sync_err_d = sat_inc(sync_err_q);
                           locked_d   = 1'b0;
                           state_d    = StHunt;
                        end
                     end else begin
                        data_d     = new_byte;
                        dval_d     = 1'b1;
                        byte_idx_d = byte_idx_q + 8'd1;
                        if (byte_idx_q == LastIdx) begin
                           pkt_cnt_d   = pkt_cnt_q + 16'd1;
                           locked_d    = 1'b1;
                           state_d     = StHunt;
                           extra_arm_d = 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  if (extra_arm_q) begin
                     len_err_d   = sat_inc(len_err_q);
                     locked_d    = 1'b0;
                     extra_arm_d = 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign data_o     = data_q;
   assign dval_o     = dval_q;
   assign strt_o     = strt_q;
   assign locked_o   = locked_q;
   assign pkt_cnt_o  = pkt_cnt_q;
   assign sync_err_o = sync_err_q;
   assign len_err_o  = len_err_q;

endmodule

// File: tb/tb_ts_serial_rx.sv
// Bench for ts_serial_rx: drives serial TS packets, scoreboards every emitted
// byte against a queue of expected bytes and checks the framing counters.
module tb_ts_serial_rx;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ts_clock = 1'b0;
   logic        ts_start = 1'b0;
   logic        ts_valid = 1'b0;
   logic        ts_data = 1'b0;
   logic        enable = 1'b0;
   logic [7:0]  data;
   logic        dval;
   logic        strt;
   logic        locked;
   logic [15:0] pkt_cnt;
   logic [7:0]  sync_err;
   logic [7:0]  len_err;

   int n_cmp = 0;
   int n_err = 0;
   int n_dval = 0;
   int n_strt = 0;
   int d0;
   int s0;

   // {strt, byte} for every byte the receiver should emit, in order
   logic [8:0] exp_q[$];

   ts_serial_rx dut (
      .clk_i      (clk),
      .reset_ni   (reset_n),
      .ts_clock_i (ts_clock),
      .ts_start_i (ts_start),
      .ts_valid_i (ts_valid),
      .ts_data_i  (ts_data),
      .enable_i   (enable),
      .data_o     (data),
      .dval_o     (dval),
      .strt_o     (strt),
      .locked_o   (locked),
      .pkt_cnt_o  (pkt_cnt),
      .sync_err_o (sync_err),
      .len_err_o  (len_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: pop the scoreboard on every dval
   always @(negedge clk) begin
      if (strt) begin
         n_strt++;
         check_eq("strt_with_dval", 32'(dval), 32'd1);
      end
      if (dval) begin
         n_dval++;
         check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check_eq("data", 32'(data), 32'(e[7:0]));
            check_eq("strt", 32'(strt), 32'(e[8]));
         end
      end
   end

   // One ts_clock period (4 clk): data changes while ts_clock is low
   task automatic send_bit(input logic b, input logic st, input logic v);
      ts_data  = b;
      ts_start = st;
      ts_valid = v;
      #20 ts_clock = 1'b1;
      #20 ts_clock = 1'b0;
   endtask

   // gap_at >= 0 inserts 5 invalid ts_clock periods after that bit position
   task automatic send_byte(input logic [7:0] b, input logic first, input int gap_at);
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i], first && (i == 7), 1'b1);
         if (gap_at == i) begin
            for (int g = 0; g < 5; g++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
         end
      end
   endtask

   function automatic logic [7:0] pkt_byte(input int k, input logic [7:0] first);
      return (k == 0) ? first : 8'(k - 1);
   endfunction

   // Sends bytes k0..len-1; pushes expectations for good-sync bytes inside PKT_LEN
   task automatic send_packet(input int len, input logic [7:0] first, input int gap_byte,
                              input int k0, input logic push);
      logic [7:0] b;
      for (int k = k0; k < len; k++) begin
         b = pkt_byte(k, first);
         if (push && first == 8'h47 && k < 188) exp_q.push_back({k == 0, b});
         send_byte(b, k == 0, (k == gap_byte) ? 3 : -1);
      end
      ts_valid = 1'b0;
      ts_start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #3;
      #40;
      check_eq("rst_dval", 32'(dval), 32'd0);
      check_eq("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
      check_eq("rst_locked", 32'(locked), 32'd0);
      reset_n = 1'b1;
      enable  = 1'b1;
      #100;

      // Two back-to-back good packets
      d0 = n_dval;
      s0 = n_strt;
      send_packet(188, 8'h47, -1, 0, 1'b1);
      send_packet(188, 8'h47, -1, 0, 1'b1);
      #200;
      check_eq("t1_pkt_cnt", 32'(pkt_cnt), 32'd2);
      check_eq("t1_locked", 32'(locked), 32'd1);
      check_eq("t1_sync_err", 32'(sync_err), 32'd0);
      check_eq("t1_len_err", 32'(len_err), 32'd0);
      check_eq("t1_dval_cnt", 32'(n_dval - d0), 32'd376);
      check_eq("t1_strt_cnt", 32'(n_strt - s0), 32'd2);

      // Bad sync byte: nothing emitted for the whole packet
      d0 = n_dval;
      send_packet(188, 8'h46, -1, 0, 1'b1);
      #200;
      check_eq("t2_sync_err", 32'(sync_err), 32'd1);
      check_eq("t2_locked", 32'(locked), 32'd0);
      check_eq("t2_dval_cnt", 32'(n_dval - d0), 32'd0);
      check_eq("t2_len_err", 32'(len_err), 32'd0);

      // Good packet with a ts_valid gap inside byte 3
      d0 = n_dval;
      send_packet(188, 8'h47, 3, 0, 1'b1);
      #200;
      check_eq("t3_pkt_cnt", 32'(pkt_cnt), 32'd3);
      check_eq("t3_locked", 32'(locked), 32'd1);
      check_eq("t3_len_err", 32'(len_err), 32'd0);
      check_eq("t3_dval_cnt", 32'(n_dval - d0), 32'd188);

      // 100-byte packet, then a 190-byte packet
      d0 = n_dval;
      send_packet(100, 8'h47, -1, 0, 1'b1);
      #200;
      check_eq("t4_len_err_pre", 32'(len_err), 32'd0);
      exp_q.push_back(9'h147);
      send_byte(8'h47, 1'b1, -1);
      check_eq("t4_len_err_short", 32'(len_err), 32'd1);
      check_eq("t4_locked_short", 32'(locked), 32'd0);
      send_packet(190, 8'h47, -1, 1, 1'b1);
      #200;
      check_eq("t4_pkt_cnt", 32'(pkt_cnt), 32'd4);
      check_eq("t4_len_err_long", 32'(len_err), 32'd2);
      check_eq("t4_locked_long", 32'(locked), 32'd0);
      check_eq("t4_dval_cnt", 32'(n_dval - d0), 32'd288);

      // Reset at byte 50
      send_packet(50, 8'h47, -1, 0, 1'b1);
      #200;
      check_eq("t5_sb_drained", 32'(exp_q.size()), 32'd0);
      reset_n = 1'b0;
      #2;
      check_eq("t5_data", 32'(data), 32'd0);
      check_eq("t5_pkt_cnt", 32'(pkt_cnt), 32'd0);
      check_eq("t5_len_err", 32'(len_err), 32'd0);
      check_eq("t5_sync_err", 32'(sync_err), 32'd0);
      check_eq("t5_locked", 32'(locked), 32'd0);
      #48 reset_n = 1'b1;
      #50;
      send_packet(188, 8'h47, -1, 0, 1'b1);
      #200;
      check_eq("t5_pkt_cnt_after", 32'(pkt_cnt), 32'd1);
      check_eq("t5_locked_after", 32'(locked), 32'd1);

      // enable dropped after byte 20: abort without error
      send_packet(20, 8'h47, -1, 0, 1'b1);
      #100 enable = 1'b0;
      #100;
      send_packet(188, 8'h47, -1, 20, 1'b0);
      enable = 1'b1;
      #100;
      send_packet(188, 8'h47, -1, 0, 1'b1);
      #200;
      check_eq("t6_pkt_cnt", 32'(pkt_cnt), 32'd2);
      check_eq("t6_len_err", 32'(len_err), 32'd0);
      check_eq("t6_sync_err", 32'(sync_err), 32'd0);
      check_eq("t6_locked", 32'(locked), 32'd1);

      // 300 bad-sync packets: sync_err saturates
      d0 = n_dval;
      for (int p = 0; p < 300; p++) begin
         send_byte(8'h00, 1'b1, -1);
         if (p == 253) begin
            #200;
            check_eq("t7_sync_err_254", 32'(sync_err), 32'd254);
         end
      end
      ts_valid = 1'b0;
      ts_start = 1'b0;
      #200;
      check_eq("t7_sync_err_sat", 32'(sync_err), 32'd255);
      check_eq("t7_len_err", 32'(len_err), 32'd0);
      check_eq("t7_locked", 32'(locked), 32'd0);
      check_eq("t7_dval_cnt", 32'(n_dval - d0), 32'd0);
      check_eq("sb_empty_end", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
